// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register carrying datapath words plus a
// packed control field; a single-entry register (SKID=0) or a 2-entry skid buffer (SKID=1).
module pipe_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int N_WORDS = 6,
    parameter int CTRL_W  = 33,
    parameter int SKID    = 1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      in_valid_in,
    output logic                      in_ready_out,
    input  logic [DATA_W*N_WORDS-1:0] data_in,
    input  logic [CTRL_W-1:0]         ctrl_in,
    input  logic                      flush_in,
    output logic                      out_valid_out,
    input  logic                      out_ready_in,
    output logic [DATA_W*N_WORDS-1:0] data_out,
    output logic [CTRL_W-1:0]         ctrl_out,
    output logic [1:0]                occ_out,
    output logic [15:0]               bubble_cnt_out
);

    localparam int DW = DATA_W * N_WORDS;

    // Handshake: an entry moves in on an edge where in_valid_in & in_ready_out,
    // and out where out_valid_out & out_ready_in; valid never depends on ready.
    logic [DW-1:0]     head_data;
    logic [DW-1:0]     skid_data;
    logic [CTRL_W-1:0] head_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [1:0]        occ;
    logic [1:0]        occ_nxt;
    logic              ready_q;
    logic              in_fire;
    logic              out_fire;
    logic              load_head_in;
    logic              load_head_skid;
    logic              load_skid_in;
    logic [15:0]       bubble_cnt;

    assign out_valid_out = (occ != 2'd0);
    assign in_ready_out  = (SKID != 0) ? ready_q : (!out_valid_out || out_ready_in);
    assign in_fire       = in_valid_in && in_ready_out;
    assign out_fire      = out_valid_out && out_ready_in;

    // occ is the stage state: 0 empty, 1 head only, 2 head plus skid
    always_comb begin
        occ_nxt        = occ;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush_in) begin
            occ_nxt = 2'd0;
        end else if (SKID == 0) begin
            if (in_fire) begin
                load_head_in = 1'b1;
                occ_nxt      = 2'd1;
            end else if (out_fire) begin
                occ_nxt = 2'd0;
            end
        end else begin
            case (occ)
                2'd0: begin
                    if (in_fire) begin
                        load_head_in = 1'b1;
                        occ_nxt      = 2'd1;
                    end
                end
                2'd1: begin
                    if (in_fire && out_fire) begin
                        load_head_in = 1'b1;
                    end else if (in_fire) begin
                        load_skid_in = 1'b1;
                        occ_nxt      = 2'd2;
                    end else if (out_fire) begin
                        occ_nxt = 2'd0;
                    end
                end
                default: begin
                    if (out_fire) begin
                        load_head_skid = 1'b1;
                        occ_nxt        = 2'd1;
                    end
                end
            endcase
        end
    end

    // Registered ready keeps out_ready_in off the in_ready_out path in skid mode
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            occ       <= 2'd0;
            ready_q   <= 1'b1;
            head_data <= '0;
            head_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            occ     <= occ_nxt;
            ready_q <= (occ_nxt != 2'd2);
            if (load_head_in) begin
                head_data <= data_in;
                head_ctrl <= ctrl_in;
            end else if (load_head_skid) begin
                head_data <= skid_data;
                head_ctrl <= skid_ctrl;
            end
            if (load_skid_in) begin
                skid_data <= data_in;
                skid_ctrl <= ctrl_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bubble_cnt <= 16'd0;
        end else if (!out_valid_out && out_ready_in && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

    // Flushed entries leave data_out stale; only ctrl_out is masked
    assign data_out       = head_data;
    assign ctrl_out       = out_valid_out ? head_ctrl : '0;
    assign occ_out        = occ;
    assign bubble_cnt_out = bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives a skid instance (SKID=1) and a plain register
// instance (SKID=0) side by side against a queue model of each.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int NW     = 6;
    localparam int CTRL_W = 33;
    localparam int DW     = DATA_W * NW;
    localparam int EW     = CTRL_W + DW;

    logic clk;
    logic rst_n;

    logic              v1, rdy1, fl1, in_ready1, out_valid1;
    logic [DW-1:0]     d1, dout1;
    logic [CTRL_W-1:0] c1, cout1;
    logic [1:0]        occ1;
    logic [15:0]       bub1_o;

    logic              v0, rdy0, fl0, in_ready0, out_valid0;
    logic [DW-1:0]     d0, dout0;
    logic [CTRL_W-1:0] c0, cout0;
    logic [1:0]        occ0;
    logic [15:0]       bub0_o;

    logic [EW-1:0] exp1_q[$];
    logic [EW-1:0] exp0_q[$];
    logic [15:0]   bub1;
    logic [15:0]   bub0;
    logic [DW-1:0] stale;
    int            checks;
    int            failures;

    pipe_stage_reg #(.DATA_W(DATA_W), .N_WORDS(NW), .CTRL_W(CTRL_W), .SKID(1)) u_dut1 (
        .clk_in(clk), .rst_in(rst_n), .in_valid_in(v1), .in_ready_out(in_ready1),
        .data_in(d1), .ctrl_in(c1), .flush_in(fl1), .out_valid_out(out_valid1),
        .out_ready_in(rdy1), .data_out(dout1), .ctrl_out(cout1), .occ_out(occ1),
        .bubble_cnt_out(bub1_o)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .N_WORDS(NW), .CTRL_W(CTRL_W), .SKID(0)) u_dut0 (
        .clk_in(clk), .rst_in(rst_n), .in_valid_in(v0), .in_ready_out(in_ready0),
        .data_in(d0), .ctrl_in(c0), .flush_in(fl0), .out_valid_out(out_valid0),
        .out_ready_in(rdy0), .data_out(dout0), .ctrl_out(cout0), .occ_out(occ0),
        .bubble_cnt_out(bub0_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_entry(output logic [DW-1:0] d, output logic [CTRL_W-1:0] c);
        for (int w = 0; w < NW; w++) d[w*DATA_W +: DATA_W] = $urandom;
        c = '0;
        c[31:0] = $urandom;
        c[CTRL_W-1] = 1'($urandom_range(0, 1));
    endtask

    // One clock: called at a negedge with inputs already driven, returns at the next negedge.
    task automatic tick();
        logic r1, r0;
        #1;
        r1 = (exp1_q.size() < 2);
        r0 = (exp0_q.size() == 0) || rdy0;
        check("in_ready1", 256'(in_ready1), 256'(r1));
        check("in_ready0", 256'(in_ready0), 256'(r0));
        if (exp1_q.size() == 0 && rdy1 && bub1 != 16'hFFFF) bub1 = bub1 + 16'd1;
        if (exp0_q.size() == 0 && rdy0 && bub0 != 16'hFFFF) bub0 = bub0 + 16'd1;
        if (fl1) exp1_q.delete();
        else begin
            if (exp1_q.size() != 0 && rdy1) void'(exp1_q.pop_front());
            if (v1 && r1) exp1_q.push_back({c1, d1});
        end
        if (fl0) exp0_q.delete();
        else begin
            if (exp0_q.size() != 0 && rdy0) void'(exp0_q.pop_front());
            if (v0 && r0) exp0_q.push_back({c0, d0});
        end
        @(posedge clk);
        @(negedge clk);
        check("occ1", 256'(occ1), 256'(exp1_q.size()));
        check("out_valid1", 256'(out_valid1), 256'(exp1_q.size() != 0));
        check("bubble1", 256'(bub1_o), 256'(bub1));
        if (exp1_q.size() != 0) check("head1", 256'({cout1, dout1}), 256'(exp1_q[0]));
        else check("ctrl1_idle", 256'(cout1), 256'(0));
        check("occ0", 256'(occ0), 256'(exp0_q.size()));
        check("out_valid0", 256'(out_valid0), 256'(exp0_q.size() != 0));
        check("bubble0", 256'(bub0_o), 256'(bub0));
        if (exp0_q.size() != 0) check("head0", 256'({cout0, dout0}), 256'(exp0_q[0]));
        else check("ctrl0_idle", 256'(cout0), 256'(0));
    endtask

    initial begin
        checks = 0; failures = 0;
        bub1 = '0; bub0 = '0;
        rst_n = 1'b0;
        v1 = 0; rdy1 = 0; fl1 = 0; d1 = '0; c1 = '0;
        v0 = 0; rdy0 = 0; fl0 = 0; d0 = '0; c0 = '0;

        // Reset values while held in reset
        repeat (2) @(negedge clk);
        #1;
        check("rst_occ1", 256'(occ1), 256'(0));
        check("rst_valid1", 256'(out_valid1), 256'(0));
        check("rst_data1", 256'(dout1), 256'(0));
        check("rst_ctrl1", 256'(cout1), 256'(0));
        check("rst_bub1", 256'(bub1_o), 256'(0));
        check("rst_ready1", 256'(in_ready1), 256'(1));
        check("rst_ready0", 256'(in_ready0), 256'(1));
        check("rst_occ0", 256'(occ0), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with downstream ready: bubbles counted
        rdy1 = 1; rdy0 = 1;
        repeat (5) tick();
        check("bubble_5", 256'(bub1_o), 256'(5));

        // Single transfer with 1-cycle latency
        v1 = 1; rand_entry(d1, c1);
        d1[31:0] = 32'h12345678; c1 = 33'h1_0000_0001;
        tick();
        v1 = 0;
        check("single_valid", 256'(out_valid1), 256'(1));
        check("single_word0", 256'(dout1[31:0]), 256'(32'h12345678));
        check("single_ctrl", 256'(cout1), 256'(33'h1_0000_0001));
        check("single_occ", 256'(occ1), 256'(1));
        tick();

        // Backpressure: A, B accepted, C blocked, then ordered drain without gaps
        rdy1 = 0;
        v1 = 1; rand_entry(d1, c1); tick();
        rand_entry(d1, c1); tick();
        check("bp_occ2", 256'(occ1), 256'(2));
        rand_entry(d1, c1);
        #1;
        check("bp_c_blocked", 256'(in_ready1), 256'(0));
        tick();
        rdy1 = 1;
        tick();
        check("bp_gap_a", 256'(out_valid1), 256'(1));
        tick();
        check("bp_gap_b", 256'(out_valid1), 256'(1));
        v1 = 0;
        tick();
        check("bp_drained", 256'(exp1_q.size()), 256'(0));

        // Random traffic on both instances, with occasional flushes
        for (int i = 0; i < 300; i++) begin
            v1 = ($urandom_range(0, 9) < 7); rdy1 = ($urandom_range(0, 9) < 6);
            fl1 = ($urandom_range(0, 31) == 0); rand_entry(d1, c1);
            v0 = ($urandom_range(0, 9) < 7); rdy0 = ($urandom_range(0, 9) < 6);
            fl0 = ($urandom_range(0, 31) == 0); rand_entry(d0, c0);
            tick();
        end
        v1 = 0; v0 = 0; fl1 = 0; fl0 = 0; rdy1 = 1; rdy0 = 1;
        repeat (3) tick();

        // SKID=0 streaming: 10 back-to-back entries
        v0 = 1;
        for (int i = 0; i < 10; i++) begin
            rand_entry(d0, c0);
            #1;
            check("s0_ready", 256'(in_ready0), 256'(1));
            tick();
            check("s0_stream_valid", 256'(out_valid0), 256'(1));
        end
        v0 = 0;
        tick();
        // SKID=0: held entry blocks input, then flush drops held and incoming
        rdy0 = 0; v0 = 1; rand_entry(d0, c0); tick();
        rand_entry(d0, c0);
        #1;
        check("s0_blocked", 256'(in_ready0), 256'(0));
        fl0 = 1; tick();
        fl0 = 0; v0 = 0; rdy0 = 1;
        tick();

        // Flush at occ=2 with an incoming entry
        rdy1 = 0; v1 = 1;
        rand_entry(d1, c1); stale = d1; tick();
        rand_entry(d1, c1); tick();
        check("fl_occ2", 256'(occ1), 256'(2));
        rand_entry(d1, c1); fl1 = 1; tick();
        fl1 = 0; v1 = 0;
        check("fl_occ0", 256'(occ1), 256'(0));
        check("fl_valid0", 256'(out_valid1), 256'(0));
        check("fl_ctrl0", 256'(cout1), 256'(0));
        check("fl_stale_data", 256'(dout1), 256'(stale));
        rdy1 = 1;
        repeat (3) begin
            tick();
            check("fl_never_out", 256'(out_valid1), 256'(0));
        end

        // Asynchronous reset between edges while occ=2
        rdy1 = 0; v1 = 1;
        rand_entry(d1, c1); tick();
        rand_entry(d1, c1); tick();
        v1 = 0;
        check("ar_occ2", 256'(occ1), 256'(2));
        #2 rst_n = 1'b0;
        #1;
        check("ar_occ0", 256'(occ1), 256'(0));
        check("ar_valid0", 256'(out_valid1), 256'(0));
        check("ar_data0", 256'(dout1), 256'(0));
        check("ar_ready1", 256'(in_ready1), 256'(1));
        exp1_q.delete(); exp0_q.delete();
        bub1 = '0; bub0 = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Bubble counter saturation
        rdy1 = 1; rdy0 = 1;
        repeat (70000) tick();
        check("bub_sat", 256'(bub1_o), 256'(16'hFFFF));
        repeat (5) tick();
        check("bub_hold", 256'(bub1_o), 256'(16'hFFFF));
        check("bub_sat0", 256'(bub0_o), 256'(16'hFFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of each datapath word.
REQ-002 SHALL have parameter N_WORDS, default 6: number of datapath words carried (rs1, rs2, pc, pc+4, iadder, imm).
REQ-003 SHALL have parameter CTRL_W, default 33: width of the packed control field (rd 5, csr addr 12, alu op 4, load size 2, load unsigned 1, alu src 1, csr wr 1, rf wr 1, wb sel 3, csr op 3).
REQ-004 SHALL have parameter SKID, default 1: 0 gives a single-entry register, 1 gives a 2-entry skid buffer.
REQ-005 SHALL have clk_in, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have rst_in, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have in_valid_in, input, 1: upstream entry valid.
REQ-008 SHALL have in_ready_out, output, 1: stage accepts an entry this cycle.
REQ-009 SHALL have data_in, input, DATA_W*N_WORDS: packed datapath words, word 0 in the LSBs.
REQ-010 SHALL have ctrl_in, input, CTRL_W: packed control field.
REQ-011 SHALL have flush_in, input, 1: synchronous kill of all held entries and the incoming entry.
REQ-012 SHALL have out_valid_out, output, 1: downstream entry valid.
REQ-013 SHALL have out_ready_in, input, 1: downstream accepts an entry.
REQ-014 SHALL have data_out, output, DATA_W*N_WORDS: head entry datapath words.
REQ-015 SHALL have ctrl_out, output, CTRL_W: head entry control; all zero whenever out_valid_out=0.
REQ-016 SHALL have occ_out, output, 2: number of entries held (0..1 when SKID=0, 0..2 when SKID=1).
REQ-017 SHALL have bubble_cnt_out, output, 16: saturating count of bubble cycles.

Function
REQ-018 SHALL transfer an entry in when in_valid_in & in_ready_out, and out when out_valid_out & out_ready_in, both at the clock edge.
REQ-019 SHALL, when SKID=0, drive in_ready_out = ~out_valid_out | out_ready_in; a simultaneous in/out transfer replaces the head entry. Latency is 1 cycle.
REQ-020 SHALL, when SKID=1, drive in_ready_out = (occ_out < 2) directly from a register, with no combinational path from out_ready_in.
REQ-021 SHALL, when SKID=1, load an accepted entry into the head register if the head is empty or is leaving the same cycle; otherwise it goes into the skid register. Latency is 1 cycle when empty.
REQ-022 SHALL, when SKID=1 and occ=2 with an out transfer, move the skid entry to the head on that edge and set occ to 1. The stage is not ready that cycle, so no entry is accepted.
REQ-023 SHALL preserve strict FIFO order; no entry may be dropped or duplicated except by flush.
REQ-024 SHALL, when flush_in=1 at an edge, set occ to 0 and drop the incoming entry regardless of handshakes. flush_in has priority over every transfer.
REQ-025 SHALL, when an entry is dropped by flush, keep the stale data_out values. ctrl_out reads zero through REQ-015.
REQ-026 SHALL increment bubble_cnt_out on each edge where out_valid_out=0 and out_ready_in=1, saturating at 0xFFFF. Only reset clears it.
REQ-027 SHALL keep occ_out consistent with out_valid_out: out_valid_out = (occ_out != 0).

Reset
REQ-028 SHALL, while rst_in=0, asynchronously force occ_out=0, out_valid_out=0, data_out=0, ctrl_out=0, bubble_cnt_out=0, and skid contents=0.
REQ-029 SHALL drive in_ready_out=1 during reset and in the first cycle after rst_in rises.
REQ-030 SHALL, on reset asserted mid-operation, discard all held entries immediately without waiting for a clock edge.

Verification
REQ-031 Reset then single transfer: in_valid=1, data word0=0x12345678, ctrl=0x1_0000_0001, out_ready=1 -> next cycle out_valid=1, data_out word0=0x12345678, ctrl_out=0x1_0000_0001, occ=1.
REQ-032 Backpressure with SKID=1: out_ready=0, push A, B, C on consecutive cycles -> A and B accepted, occ=2, in_ready=0 when C is offered. Then out_ready=1 -> A, B, C emerge in order with no gaps after C is accepted.
REQ-033 Flush with SKID=1: occ=2 and flush=1 while in_valid=1 -> next cycle occ=0, out_valid=0, ctrl_out=0, and the incoming entry is never output.
REQ-034 Async reset mid-stream: rst_in low between clock edges while occ=2 -> occ=0 and out_valid=0 before the next edge.
REQ-035 Bubble counter: out_ready=1 and in_valid=0 for 70000 cycles -> bubble_cnt_out=0xFFFF and holds there.
REQ-036 SKID=0 streaming: in_valid=1 and out_ready=1 continuously for 10 entries -> 10 outputs on consecutive cycles, in_ready held at 1.
